// File: rtl/handshake_latency_monitor_if.sv
// Bundles the req/ack handshake, the monitor controls and the per-channel event outputs.
// Ports: en, clr_err, req, ack (driven by the observed side / master);
//        busy, pass, err_early, err_timeout, err_spurious, err_sticky, err_cnt (driven by the monitor / slave).
interface handshake_latency_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  logic              en;
  logic              clr_err;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] ack;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] pass;
  logic [NUM_CH-1:0] err_early;
  logic [NUM_CH-1:0] err_timeout;
  logic [NUM_CH-1:0] err_spurious;
  logic              err_sticky;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output en, clr_err, req, ack,
    input  busy, pass, err_early, err_timeout, err_spurious, err_sticky, err_cnt
  );

  modport slave (
    input  en, clr_err, req, ack,
    output busy, pass, err_early, err_timeout, err_spurious, err_sticky, err_cnt
  );
endinterface

// File: rtl/handshake_latency_monitor.sv
// Per-channel req->ack latency checker: flags acks that are early, late (timeout) or unsolicited,
// and aggregates errors into a sticky flag and a saturating counter. All outputs registered (1 cycle).
// Ports: clk, rst (async active-high), mon (slave modport: en/clr_err/req/ack in, events/busy/err_* out).
module handshake_latency_monitor #(
  parameter int NUM_CH  = 4,
  parameter int MIN_LAT = 2,
  parameter int MAX_LAT = 4,
  parameter int CNT_W   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  handshake_latency_monitor_if.slave    mon
);
  localparam int LAT_W = $clog2(MAX_LAT + 2);
  localparam int N_W   = $clog2(NUM_CH + 1);
  localparam int SUM_W = CNT_W + N_W;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  generate
    if (NUM_CH < 1 || MIN_LAT < 1 || MAX_LAT < MIN_LAT) begin : g_bad_params
      $error("handshake_latency_monitor: illegal NUM_CH/MIN_LAT/MAX_LAT combination");
    end
  endgenerate

  state_t            state_q [NUM_CH];
  state_t            state_d [NUM_CH];
  logic [LAT_W-1:0]  lat_q   [NUM_CH];
  logic [LAT_W-1:0]  lat_d   [NUM_CH];
  logic [NUM_CH-1:0] pass_q, pass_d;
  logic [NUM_CH-1:0] early_q, early_d;
  logic [NUM_CH-1:0] timeout_q, timeout_d;
  logic [NUM_CH-1:0] spur_q, spur_d;
  logic              sticky_q, sticky_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_W-1:0]    n_err;
  logic [CNT_W-1:0]  cnt_base;
  logic [SUM_W-1:0]  cnt_sum;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]   = state_q[i];
      lat_d[i]     = lat_q[i];
      pass_d[i]    = 1'b0;
      early_d[i]   = 1'b0;
      timeout_d[i] = 1'b0;
      spur_d[i]    = 1'b0;
      if (!mon.en) begin
        state_d[i] = IDLE;
        lat_d[i]   = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (mon.req[i]) begin
              // a req sampled together with an ack arms the channel; the ack is not spurious
              state_d[i] = WAIT;
              lat_d[i]   = LAT_W'(1);
            end else if (mon.ack[i]) begin
              spur_d[i] = 1'b1;
            end
          end
          WAIT: begin
            if (mon.ack[i] || lat_q[i] >= LAT_W'(MAX_LAT)) begin
              if (mon.ack[i]) begin
                if (lat_q[i] < LAT_W'(MIN_LAT)) early_d[i] = 1'b1;
                else                            pass_d[i]  = 1'b1;
              end else begin
                timeout_d[i] = 1'b1;
              end
              // the request that closes the window on the same edge starts a new one
              if (mon.req[i]) begin
                state_d[i] = WAIT;
                lat_d[i]   = LAT_W'(1);
              end else begin
                state_d[i] = IDLE;
                lat_d[i]   = '0;
              end
            end else begin
              // req while waiting is ignored: the outstanding window keeps running
              lat_d[i] = lat_q[i] + LAT_W'(1);
            end
          end
        endcase
      end
    end

    n_err = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      n_err = n_err + N_W'(early_d[i] | timeout_d[i] | spur_d[i]);
    end

    // errors on the clearing edge survive the clear
    cnt_base = mon.clr_err ? '0 : cnt_q;
    cnt_sum  = SUM_W'(cnt_base) + SUM_W'(n_err);
    cnt_d    = (cnt_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    sticky_d = (n_err != '0) | (sticky_q & ~mon.clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        lat_q[i]   <= '0;
      end
      pass_q    <= '0;
      early_q   <= '0;
      timeout_q <= '0;
      spur_q    <= '0;
      sticky_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        lat_q[i]   <= lat_d[i];
      end
      pass_q    <= pass_d;
      early_q   <= early_d;
      timeout_q <= timeout_d;
      spur_q    <= spur_d;
      sticky_q  <= sticky_d;
      cnt_q     <= cnt_d;
    end
  end

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_busy
      assign mon.busy[g] = (state_q[g] == WAIT);
    end
  endgenerate

  assign mon.pass         = pass_q;
  assign mon.err_early    = early_q;
  assign mon.err_timeout  = timeout_q;
  assign mon.err_spurious = spur_q;
  assign mon.err_sticky   = sticky_q;
  assign mon.err_cnt      = cnt_q;
endmodule

// File: tb/tb_handshake_latency_monitor.sv
module tb_handshake_latency_monitor;
  logic clk;
  logic rst;

  handshake_latency_monitor_if #(.NUM_CH(4), .CNT_W(8)) ifa ();
  handshake_latency_monitor_if #(.NUM_CH(4), .CNT_W(2)) ifb ();

  handshake_latency_monitor #(.NUM_CH(4), .MIN_LAT(2), .MAX_LAT(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .mon(ifa.slave)
  );
  handshake_latency_monitor #(.NUM_CH(4), .MIN_LAT(2), .MAX_LAT(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .mon(ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       clr;
    logic [3:0] req;
    logic [3:0] ack;
    logic [3:0] busy;
    logic [3:0] pass;
    logic [3:0] early;
    logic [3:0] tmo;
    logic [3:0] spur;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    logic       sticky;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic add(input logic en, input logic clr, input logic [3:0] req, input logic [3:0] ack,
                     input logic [3:0] busy, input logic [3:0] pass, input logic [3:0] early,
                     input logic [3:0] tmo, input logic [3:0] spur, input logic [7:0] cnt,
                     input logic [1:0] cnt2, input logic sticky);
    vec_t v;
    v.en = en; v.clr = clr; v.req = req; v.ack = ack;
    v.busy = busy; v.pass = pass; v.early = early; v.tmo = tmo; v.spur = spur;
    v.cnt = cnt; v.cnt2 = cnt2; v.sticky = sticky;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic en, input logic clr, input logic [3:0] req, input logic [3:0] ack);
    ifa.en = en; ifa.clr_err = clr; ifa.req = req; ifa.ack = ack;
    ifb.en = en; ifb.clr_err = clr; ifb.req = req; ifb.ack = ack;
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] req_v);
    n_chk++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h, expected %0h", nm, row, act, req_v);
    end
  endtask

  task automatic chk_all_zero(input string nm, input int row);
    chk({nm, "_busy"},   row, 32'(ifa.busy), 32'h0);
    chk({nm, "_events"}, row, 32'(ifa.pass | ifa.err_early | ifa.err_timeout | ifa.err_spurious), 32'h0);
    chk({nm, "_cnt"},    row, 32'(ifa.err_cnt), 32'h0);
    chk({nm, "_sticky"}, row, 32'(ifa.err_sticky), 32'h0);
    chk({nm, "_cnt2"},   row, 32'(ifb.err_cnt), 32'h0);
  endtask

  initial begin
    vec_t e;
    //   en clr req   ack   | busy  pass  early tmo   spur  cnt    cnt2  sticky
    // single request answered inside the window (latency 3)
    add(1, 0, 4'h1, 4'h0,   4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 2'd0, 0);
    add(1, 0, 4'h0, 4'h0,   4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 2'd0, 0);
    add(1, 0, 4'h0, 4'h0,   4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 2'd0, 0);
    add(1, 0, 4'h0, 4'h1,   4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 8'd0, 2'd0, 0);
    add(1, 0, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 2'd0, 0);
    // unanswered request times out 4 edges after the req
    add(1, 0, 4'h1, 4'h0,   4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 2'd0, 0);
    add(1, 0, 4'h0, 4'h0,   4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 2'd0, 0);
    add(1, 0, 4'h0, 4'h0,   4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 2'd0, 0);
    add(1, 0, 4'h0, 4'h0,   4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 2'd0, 0);
    add(1, 0, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 8'd1, 2'd1, 1);
    // early ack on ch1, spurious ack on ch2
    add(1, 0, 4'h2, 4'h0,   4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 8'd1, 2'd1, 1);
    add(1, 0, 4'h0, 4'h2,   4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 8'd2, 2'd2, 1);
    add(1, 0, 4'h0, 4'h4,   4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 8'd3, 2'd3, 1);
    // ack at MAX_LAT with a new req re-arms, second window times out
    add(1, 0, 4'h1, 4'h0,   4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 8'd3, 2'd3, 1);
    add(1, 0, 4'h0, 4'h0,   4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 8'd3, 2'd3, 1);
    add(1, 0, 4'h0, 4'h0,   4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 8'd3, 2'd3, 1);
    add(1, 0, 4'h0, 4'h0,   4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 8'd3, 2'd3, 1);
    add(1, 0, 4'h1, 4'h1,   4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 8'd3, 2'd3, 1);
    add(1, 0, 4'h0, 4'h0,   4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 8'd3, 2'd3, 1);
    add(1, 0, 4'h0, 4'h0,   4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 8'd3, 2'd3, 1);
    add(1, 0, 4'h0, 4'h0,   4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 8'd3, 2'd3, 1);
    add(1, 0, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 8'd4, 2'd3, 1);
    // clear, then four simultaneous timeouts (2-bit counter saturates)
    add(1, 1, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 2'd0, 0);
    add(1, 0, 4'hF, 4'h0,   4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 2'd0, 0);
    add(1, 0, 4'h0, 4'h0,   4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 2'd0, 0);
    add(1, 0, 4'h0, 4'h0,   4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 2'd0, 0);
    add(1, 0, 4'h0, 4'h0,   4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 2'd0, 0);
    add(1, 0, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 8'd4, 2'd3, 1);
    // req while waiting is ignored; clr_err on the timeout edge keeps the new error
    add(1, 0, 4'h1, 4'h0,   4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 8'd4, 2'd3, 1);
    add(1, 0, 4'h0, 4'h0,   4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 8'd4, 2'd3, 1);
    add(1, 0, 4'h1, 4'h0,   4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 8'd4, 2'd3, 1);
    add(1, 0, 4'h0, 4'h0,   4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 8'd4, 2'd3, 1);
    add(1, 1, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 8'd1, 2'd1, 1);
    // req+ack together in IDLE arms without spurious; answered at MIN_LAT
    add(1, 0, 4'h4, 4'h4,   4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 8'd1, 2'd1, 1);
    add(1, 0, 4'h0, 4'h0,   4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 8'd1, 2'd1, 1);
    add(1, 0, 4'h0, 4'h4,   4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 8'd1, 2'd1, 1);
    // concurrent events on different channels
    add(1, 0, 4'h2, 4'h8,   4'h2, 4'h0, 4'h0, 4'h0, 4'h8, 8'd2, 2'd2, 1);
    add(1, 0, 4'h0, 4'h2,   4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 8'd3, 2'd3, 1);
    add(1, 0, 4'h0, 4'h3,   4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 8'd5, 2'd3, 1);
    // disabled: no events, counters hold, clear still works; stale acks are spurious
    add(0, 0, 4'hF, 4'h0,   4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd5, 2'd3, 1);
    add(0, 0, 4'h0, 4'hF,   4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd5, 2'd3, 1);
    add(0, 1, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 2'd0, 0);
    add(1, 0, 4'h0, 4'h1,   4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 8'd1, 2'd1, 1);
    add(1, 0, 4'h1, 4'h0,   4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 8'd1, 2'd1, 1);
    add(0, 0, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd1, 2'd1, 1);
    add(1, 0, 4'h0, 4'h1,   4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 8'd2, 2'd2, 1);
    add(1, 0, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd2, 2'd2, 1);

    // reset state
    rst = 1'b0;
    drive(0, 0, 4'h0, 4'h0);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset", 0);
    @(negedge clk);
    rst = 1'b0;

    // table: stimulus pushes the expectation, the post-edge sample pops it
    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      drive(vecs[k].en, vecs[k].clr, vecs[k].req, vecs[k].ack);
      exp_q.push_back(vecs[k]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("busy",        k, 32'(ifa.busy),         32'(e.busy));
      chk("pass",        k, 32'(ifa.pass),         32'(e.pass));
      chk("err_early",   k, 32'(ifa.err_early),    32'(e.early));
      chk("err_timeout", k, 32'(ifa.err_timeout),  32'(e.tmo));
      chk("err_spur",    k, 32'(ifa.err_spurious), 32'(e.spur));
      chk("err_cnt",     k, 32'(ifa.err_cnt),      32'(e.cnt));
      chk("err_cnt_w2",  k, 32'(ifb.err_cnt),      32'(e.cnt2));
      chk("err_sticky",  k, 32'(ifa.err_sticky),   32'(e.sticky));
    end

    // async reset in the middle of a wait window aborts it silently
    @(negedge clk);
    drive(1, 0, 4'h1, 4'h0);
    @(posedge clk);
    #1;
    chk("rst_pre_busy", 0, 32'(ifa.busy), 32'h1);
    @(negedge clk);
    drive(1, 0, 4'h0, 4'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("rst_async", 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk_all_zero("rst_after", k);
    end

    // disabled with random req/ack traffic: nothing reported
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(0, 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      @(posedge clk);
      #1;
      chk_all_zero("en_off", k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
